// File: rtl/wbm2axi_lanes_pkg.sv
// Shared AXI bus encodings and the bridge state type for the Wishbone-to-AXI lane bridge.
package wbm2axi_lanes_pkg;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUFMOD = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/wbm2axi_lanes_sfifo.sv
// Small synchronous show-ahead FIFO; holds the AXI lane of every outstanding read.
module wbm2axi_lanes_sfifo #(
    parameter int DW     = 2,
    parameter int LGFLEN = 5
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0]     mem_q [2**LGFLEN];
    logic [LGFLEN-1:0] wr_q, wr_d;
    logic [LGFLEN-1:0] rd_q, rd_d;

    always_comb begin
        wr_d = wr_q + LGFLEN'(i_push);
        rd_d = rd_q + LGFLEN'(i_pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push)
            mem_q[wr_q] <= i_data;
    end

    assign o_data = mem_q[rd_q];

endmodule

// File: rtl/wbm2axi_lanes.sv
// Pipelined Wishbone master to AXI4 bridge: single-beat transactions, narrow WB words
// placed in the matching AXI byte lane, error returns and abort-on-cycle-drop.
module wbm2axi_lanes
    import wbm2axi_lanes_pkg::*;
#(
    parameter int AXI_DW  = 128,
    parameter int WB_DW   = 32,
    parameter int AXI_AW  = 28,
    parameter int AXI_IDW = 1,
    parameter int LGFIFO  = 5
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_wb_cyc,
    input  logic                              i_wb_stb,
    input  logic                              i_wb_we,
    input  logic [AXI_AW-$clog2(WB_DW/8)-1:0] i_wb_addr,
    input  logic [WB_DW-1:0]                  i_wb_data,
    input  logic [WB_DW/8-1:0]                i_wb_sel,
    output logic                              o_wb_stall,
    output logic                              o_wb_ack,
    output logic                              o_wb_err,
    output logic [WB_DW-1:0]                  o_wb_data,
    output logic                              o_axi_awvalid,
    input  logic                              i_axi_awready,
    output logic [AXI_AW-1:0]                 o_axi_awaddr,
    output logic [7:0]                        o_axi_awlen,
    output logic [2:0]                        o_axi_awsize,
    output logic [1:0]                        o_axi_awburst,
    output logic                              o_axi_awlock,
    output logic [3:0]                        o_axi_awcache,
    output logic [2:0]                        o_axi_awprot,
    output logic [3:0]                        o_axi_awqos,
    output logic [AXI_IDW-1:0]                o_axi_awid,
    output logic                              o_axi_wvalid,
    input  logic                              i_axi_wready,
    output logic [AXI_DW-1:0]                 o_axi_wdata,
    output logic [AXI_DW/8-1:0]               o_axi_wstrb,
    output logic                              o_axi_wlast,
    input  logic                              i_axi_bvalid,
    input  logic [1:0]                        i_axi_bresp,
    input  logic [AXI_IDW-1:0]                i_axi_bid,
    output logic                              o_axi_bready,
    output logic                              o_axi_arvalid,
    input  logic                              i_axi_arready,
    output logic [AXI_AW-1:0]                 o_axi_araddr,
    output logic [7:0]                        o_axi_arlen,
    output logic [2:0]                        o_axi_arsize,
    output logic [1:0]                        o_axi_arburst,
    output logic                              o_axi_arlock,
    output logic [3:0]                        o_axi_arcache,
    output logic [2:0]                        o_axi_arprot,
    output logic [3:0]                        o_axi_arqos,
    output logic [AXI_IDW-1:0]                o_axi_arid,
    input  logic                              i_axi_rvalid,
    input  logic [AXI_DW-1:0]                 i_axi_rdata,
    input  logic [1:0]                        i_axi_rresp,
    input  logic                              i_axi_rlast,
    input  logic [AXI_IDW-1:0]                i_axi_rid,
    output logic                              o_axi_rready,
    output state_e                            o_dbg_state
);

    localparam int RATIO = AXI_DW / WB_DW;
    localparam int LGR   = $clog2(RATIO);
    localparam int LANEW = (LGR > 0) ? LGR : 1;
    localparam int WBB   = $clog2(WB_DW / 8);
    localparam int CNTW  = LGFIFO + 1;
    localparam logic [CNTW-1:0]   CNT_FULL  = CNTW'(1) << LGFIFO;
    localparam logic [AXI_AW-1:0] ADDR_MASK = ~((AXI_AW'(1) << $clog2(AXI_DW/8)) - AXI_AW'(1));

    // Handshakes: a valid, once raised, stays high with its payload frozen until the
    // cycle its ready is seen; AW and W retire independently, B and R are always ready.
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [AXI_AW-1:0]   addr_q, addr_d;
    logic [AXI_DW-1:0]   wdata_q, wdata_d;
    logic [AXI_DW/8-1:0] wstrb_q, wstrb_d, strb_ext;
    logic                ack_q, ack_d, err_q, err_d, dir_q, dir_d;
    logic [WB_DW-1:0]    rdata_q, rdata_d;
    logic [CNTW-1:0]     count_q, count_d;
    state_e              state_q, state_d;
    logic                stall, accept, ret_valid, ret_err, report, flush_go;
    logic                lane_push, lane_pop;
    logic [LANEW-1:0]    wb_lane, ret_lane;
    logic                unused_inputs;

    generate
        if (RATIO > 1) begin : g_lanes
            assign wb_lane = i_wb_addr[LGR-1:0];
            wbm2axi_lanes_sfifo #(.DW(LANEW), .LGFLEN(LGFIFO)) u_lane_fifo (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_push    (lane_push),
                .i_data    (wb_lane),
                .i_pop     (lane_pop),
                .o_data    (ret_lane)
            );
        end else begin : g_no_lanes
            assign wb_lane  = '0;
            assign ret_lane = '0;
        end
    endgenerate

    always_comb begin
        stall = (awvalid_q && !i_axi_awready) || (wvalid_q && !i_axi_wready)
             || (arvalid_q && !i_axi_arready) || (count_q == CNT_FULL)
             || ((count_q != '0) && (dir_q != i_wb_we)) || (state_q == ST_FLUSH);
        accept    = i_wb_cyc && i_wb_stb && !stall;
        // Returns only count while something is outstanding, so stray beats after reset vanish.
        ret_valid = (count_q != '0) && (dir_q ? i_axi_bvalid : i_axi_rvalid);
        ret_err   = dir_q ? i_axi_bresp[1] : i_axi_rresp[1];
        report    = ret_valid && i_wb_cyc && (state_q != ST_FLUSH);
        lane_push = accept && !i_wb_we;
        lane_pop  = ret_valid && !dir_q;
        strb_ext  = '0;
        strb_ext[WB_DW/8-1:0] = i_wb_sel;

        awvalid_d = awvalid_q && !i_axi_awready;
        wvalid_d  = wvalid_q && !i_axi_wready;
        arvalid_d = arvalid_q && !i_axi_arready;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        dir_d     = dir_q;
        if (accept) begin
            awvalid_d = i_wb_we;
            wvalid_d  = i_wb_we;
            arvalid_d = !i_wb_we;
            addr_d    = (AXI_AW'(i_wb_addr) << WBB) & ADDR_MASK;
            wdata_d   = {RATIO{i_wb_data}};
            wstrb_d   = strb_ext << (wb_lane * (WB_DW / 8));
            dir_d     = i_wb_we;
        end

        count_d = count_q + CNTW'(accept) - CNTW'(ret_valid);
        ack_d   = report && !ret_err;
        err_d   = report && ret_err;
        rdata_d = rdata_q;
        if (lane_pop)
            rdata_d = i_axi_rdata[ret_lane*WB_DW +: WB_DW];

        flush_go = (state_q == ST_FLUSH) || (!i_wb_cyc && (count_q != '0))
                || (ret_valid && ret_err);
        if (count_d == '0)
            state_d = ST_IDLE;
        else if (flush_go)
            state_d = ST_FLUSH;
        else
            state_d = ST_BUSY;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            dir_q     <= 1'b0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            state_q   <= ST_IDLE;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            dir_q     <= dir_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            state_q   <= state_d;
        end
    end

    assign unused_inputs = ^{i_axi_bid, i_axi_rid, i_axi_rlast, i_axi_bresp[0], i_axi_rresp[0]};

    assign o_wb_stall    = stall;
    assign o_wb_ack      = ack_q;
    assign o_wb_err      = err_q;
    assign o_wb_data     = rdata_q;
    assign o_dbg_state   = state_q;

    assign o_axi_awvalid = awvalid_q;
    assign o_axi_awaddr  = addr_q;
    assign o_axi_awlen   = 8'd0;
    assign o_axi_awsize  = 3'($clog2(AXI_DW/8));
    assign o_axi_awburst = AXI_BURST_INCR;
    assign o_axi_awlock  = 1'b0;
    assign o_axi_awcache = AXI_CACHE_BUFMOD;
    assign o_axi_awprot  = 3'd0;
    assign o_axi_awqos   = 4'd0;
    assign o_axi_awid    = '0;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wlast   = 1'b1;
    assign o_axi_bready  = 1'b1;

    assign o_axi_arvalid = arvalid_q;
    assign o_axi_araddr  = addr_q;
    assign o_axi_arlen   = 8'd0;
    assign o_axi_arsize  = 3'($clog2(AXI_DW/8));
    assign o_axi_arburst = AXI_BURST_INCR;
    assign o_axi_arlock  = 1'b0;
    assign o_axi_arcache = AXI_CACHE_BUFMOD;
    assign o_axi_arprot  = 3'd0;
    assign o_axi_arqos   = 4'd0;
    assign o_axi_arid    = '0;
    assign o_axi_rready  = 1'b1;

endmodule

// File: tb/tb_wbm2axi_lanes.sv
// Directed bench for wbm2axi_lanes: single-transaction vector table plus multi-cycle sequences.
module tb_wbm2axi_lanes;
    import wbm2axi_lanes_pkg::*;

    localparam logic [127:0] R0 = 128'h44444444_33333333_22222222_11111111;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cyc, stb, we;
    logic [25:0]   addr;
    logic [31:0]   wb_wdata;
    logic [3:0]    sel;
    logic          stall, ack, err;
    logic [31:0]   wb_rdata;
    logic          awvalid, awready, awlock, wvalid, wready, wlast;
    logic [27:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, awprot, arsize, arprot;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [3:0]    awcache, awqos, arcache, arqos;
    logic [0:0]    awid, arid, bid, rid;
    logic [127:0]  wdata, rdata;
    logic [15:0]   wstrb;
    logic          bvalid, bready, arvalid, arready, arlock, rvalid, rlast, rready;
    state_e        dbg_state;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [31:0]   exp_q[$];

    typedef struct {
        logic         we;
        logic [25:0]  addr;
        logic [3:0]   sel;
        logic [31:0]  wdata;
        logic [1:0]   resp;
        logic [127:0] rdata;
        logic [27:0]  exp_addr;
        logic [15:0]  exp_strb;
        logic         exp_ack;
        logic         exp_err;
        logic [31:0]  exp_data;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    wbm2axi_lanes dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wb_wdata), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(wb_rdata),
        .o_axi_awvalid(awvalid), .i_axi_awready(awready), .o_axi_awaddr(awaddr),
        .o_axi_awlen(awlen), .o_axi_awsize(awsize), .o_axi_awburst(awburst),
        .o_axi_awlock(awlock), .o_axi_awcache(awcache), .o_axi_awprot(awprot),
        .o_axi_awqos(awqos), .o_axi_awid(awid),
        .o_axi_wvalid(wvalid), .i_axi_wready(wready), .o_axi_wdata(wdata),
        .o_axi_wstrb(wstrb), .o_axi_wlast(wlast),
        .i_axi_bvalid(bvalid), .i_axi_bresp(bresp), .i_axi_bid(bid), .o_axi_bready(bready),
        .o_axi_arvalid(arvalid), .i_axi_arready(arready), .o_axi_araddr(araddr),
        .o_axi_arlen(arlen), .o_axi_arsize(arsize), .o_axi_arburst(arburst),
        .o_axi_arlock(arlock), .o_axi_arcache(arcache), .o_axi_arprot(arprot),
        .o_axi_arqos(arqos), .o_axi_arid(arid),
        .i_axi_rvalid(rvalid), .i_axi_rdata(rdata), .i_axi_rresp(rresp),
        .i_axi_rlast(rlast), .i_axi_rid(rid), .o_axi_rready(rready),
        .o_dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_quiet();
        cyc = 0; stb = 0; we = 0; addr = '0; wb_wdata = '0; sel = 4'hF;
        awready = 1; wready = 1; arready = 1;
        bvalid = 0; bresp = 2'b00; bid = '0;
        rvalid = 0; rresp = 2'b00; rdata = '0; rlast = 1; rid = '0;
    endtask

    task automatic issue_reads(input int n, input logic [25:0] base);
        cyc = 1; stb = 1; we = 0;
        for (int i = 0; i < n; i++) begin
            addr = base + 26'(i);
            tick();
        end
        stb = 0;
    endtask

    initial begin
        int n_ack;
        logic [127:0] beat;

        vecs[0] = '{1'b1, 26'h0000005, 4'hF, 32'hDEADBEEF, AXI_RESP_OKAY,   128'h0, 28'h0000010, 16'h00F0, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 26'h0000003, 4'h5, 32'h12345678, AXI_RESP_OKAY,   128'h0, 28'h0000000, 16'h5000, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 26'h0000100, 4'h8, 32'hA5A50F0F, AXI_RESP_SLVERR, 128'h0, 28'h0000400, 16'h0008, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 26'h0000006, 4'hF, 32'h0,        AXI_RESP_OKAY,   R0,     28'h0000010, 16'h0,    1'b1, 1'b0, 32'h33333333};
        vecs[4] = '{1'b0, 26'h3FFFFFF, 4'hF, 32'h0,        AXI_RESP_OKAY,   R0,     28'hFFFFFF0, 16'h0,    1'b1, 1'b0, 32'h44444444};
        vecs[5] = '{1'b0, 26'h0000009, 4'hF, 32'h0,        AXI_RESP_DECERR, R0,     28'h0000020, 16'h0,    1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 26'h0000002, 4'h3, 32'hCAFEF00D, AXI_RESP_EXOKAY, 128'h0, 28'h0000000, 16'h0300, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 26'h0000010, 4'hF, 32'h0,        AXI_RESP_OKAY,   R0,     28'h0000040, 16'h0,    1'b1, 1'b0, 32'h11111111};

        // Reset values
        bus_quiet();
        reset_n = 0;
        tick();
        tick();
        chk("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        chk("rst_ack_err", {ack, err}, 2'b00);
        chk("rst_data", wb_rdata, 32'h0);
        chk("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        chk("rst_stall", stall, 1'b0);
        reset_n = 1;
        tick();
        chk("const_aw", {awlen, awsize, awburst, awlock, awcache, awprot, awqos, awid},
            {8'd0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0});
        chk("const_ar", {arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid},
            {8'd0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0});
        chk("const_ready_last", {bready, rready, wlast}, 3'b111);

        // Single transactions from the table
        for (int i = 0; i < 8; i++) begin
            cyc = 1; stb = 1; we = vecs[i].we; addr = vecs[i].addr;
            sel = vecs[i].sel; wb_wdata = vecs[i].wdata;
            @(negedge clk);
            chk("vec_stall", stall, 1'b0);
            tick();
            stb = 0;
            if (vecs[i].we) begin
                chk("vec_aw_w_valid", {awvalid, wvalid, arvalid}, 3'b110);
                chk("vec_awaddr", awaddr, vecs[i].exp_addr);
                chk("vec_wstrb", wstrb, vecs[i].exp_strb);
                chk("vec_wdata", wdata, {4{vecs[i].wdata}});
            end else begin
                chk("vec_ar_valid", {awvalid, wvalid, arvalid}, 3'b001);
                chk("vec_araddr", araddr, vecs[i].exp_addr);
            end
            chk("vec_busy", 128'(dbg_state), 128'(ST_BUSY));
            tick();
            chk("vec_valid_drop", {awvalid, wvalid, arvalid}, 3'b000);
            if (vecs[i].we) begin
                bvalid = 1; bresp = vecs[i].resp;
            end else begin
                rvalid = 1; rresp = vecs[i].resp; rdata = vecs[i].rdata;
            end
            tick();
            bvalid = 0; rvalid = 0;
            chk("vec_ack", ack, vecs[i].exp_ack);
            chk("vec_err", err, vecs[i].exp_err);
            if (!vecs[i].we && vecs[i].exp_ack)
                chk("vec_rdata", wb_rdata, vecs[i].exp_data);
            chk("vec_idle", 128'(dbg_state), 128'(ST_IDLE));
            tick();
            chk("vec_pulse", {ack, err}, 2'b00);
            cyc = 0;
            tick();
        end

        // Back-to-back read burst, lanes 0..3 twice
        bus_quiet();
        cyc = 1; stb = 1; we = 0;
        for (int i = 0; i < 8; i++) begin
            addr = 26'(i);
            @(negedge clk);
            chk("burst_stall", stall, 1'b0);
            tick();
            chk("burst_arvalid", arvalid, 1'b1);
            chk("burst_araddr", araddr, 28'((i / 4) * 16));
        end
        stb = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++)
                beat[k*32 +: 32] = 32'hA0000000 + 32'(i * 16 + k);
            exp_q.push_back(32'hA0000000 + 32'(i * 16 + (i % 4)));
            rvalid = 1; rdata = beat;
            tick();
            chk("burst_ack", ack, 1'b1);
            chk("burst_data", wb_rdata, exp_q.pop_front());
        end
        rvalid = 0;
        tick();
        chk("burst_end_ack", ack, 1'b0);
        chk("burst_end_idle", 128'(dbg_state), 128'(ST_IDLE));
        cyc = 0;
        tick();

        // arready held low, then fill to the outstanding cap
        cyc = 1; stb = 1; we = 0; addr = '0; arready = 0;
        @(negedge clk);
        chk("cap_first_stall", stall, 1'b0);
        tick();
        @(negedge clk);
        chk("cap_stall_after_one", stall, 1'b1);
        repeat (40) tick();
        chk("cap_arvalid_held", arvalid, 1'b1);
        chk("cap_stall_held", stall, 1'b1);
        arready = 1;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            chk("cap_fill_nostall", stall, 1'b0);
            tick();
        end
        @(negedge clk);
        chk("cap_full_stall", stall, 1'b1);
        tick();
        rvalid = 1; rresp = 2'b00; rdata = R0;
        @(negedge clk);
        chk("cap_full_with_ret", stall, 1'b1);
        tick();
        rvalid = 0;
        chk("cap_ret_ack", ack, 1'b1);
        @(negedge clk);
        chk("cap_unstall_after_ret", stall, 1'b0);
        tick();
        stb = 0;
        @(negedge clk);
        chk("cap_refull", stall, 1'b1);
        n_ack = 0;
        rvalid = 1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (ack) n_ack++;
        end
        rvalid = 0;
        chk("cap_drain_acks", n_ack, 32);
        tick();
        chk("cap_no_extra_ack", ack, 1'b0);
        chk("cap_idle", 128'(dbg_state), 128'(ST_IDLE));
        cyc = 0;
        tick();

        // Write then read back to back: read waits for B
        cyc = 1; stb = 1; we = 1; addr = 26'h5; sel = 4'hF; wb_wdata = 32'h1;
        tick();
        we = 0; addr = 26'h6;
        @(negedge clk);
        chk("dir_conflict_stall", stall, 1'b1);
        repeat (3) tick();
        chk("dir_no_ar", arvalid, 1'b0);
        bvalid = 1; bresp = AXI_RESP_OKAY;
        @(negedge clk);
        chk("dir_stall_on_b", stall, 1'b1);
        tick();
        bvalid = 0;
        chk("dir_wr_ack", ack, 1'b1);
        @(negedge clk);
        chk("dir_rd_unstall", stall, 1'b0);
        tick();
        stb = 0;
        chk("dir_ar_after_b", arvalid, 1'b1);
        chk("dir_araddr", araddr, 28'h10);
        rvalid = 1; rdata = R0;
        tick();
        rvalid = 0;
        chk("dir_rd_ack", ack, 1'b1);
        chk("dir_rd_data", wb_rdata, 32'h33333333);
        cyc = 0;
        tick();

        // Cycle drop with 4 reads outstanding
        issue_reads(4, 26'h0);
        cyc = 0;
        tick();
        chk("abort_flush", 128'(dbg_state), 128'(ST_FLUSH));
        cyc = 1; stb = 1; we = 0; addr = 26'h20;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1; rresp = 2'b00; rdata = R0;
            @(negedge clk);
            chk("abort_stall", stall, 1'b1);
            tick();
            chk("abort_no_ack", {ack, err}, 2'b00);
        end
        rvalid = 0;
        @(negedge clk);
        chk("abort_unstall", stall, 1'b0);
        tick();
        stb = 0;
        chk("abort_next_ar", arvalid, 1'b1);
        chk("abort_next_araddr", araddr, 28'h80);
        rvalid = 1;
        tick();
        rvalid = 0;
        chk("abort_next_ack", ack, 1'b1);
        chk("abort_next_data", wb_rdata, 32'h11111111);
        cyc = 0;
        tick();

        // Error on beat 2 of 5
        issue_reads(5, 26'h0);
        for (int b = 1; b <= 5; b++) begin
            rvalid = 1; rdata = R0;
            rresp = (b == 2) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (b >= 3) begin
                @(negedge clk);
                chk("errb_flush_stall", stall, 1'b1);
            end
            tick();
            chk("errb_ack", ack, (b == 1));
            chk("errb_err", err, (b == 2));
        end
        rvalid = 0; rresp = 2'b00;
        chk("errb_idle", 128'(dbg_state), 128'(ST_IDLE));
        cyc = 0;
        tick();

        // Reset mid-transaction, stray beat afterwards
        issue_reads(2, 26'h0);
        reset_n = 0;
        tick();
        reset_n = 1;
        chk("mid_rst_idle", 128'(dbg_state), 128'(ST_IDLE));
        chk("mid_rst_arvalid", arvalid, 1'b0);
        rvalid = 1; rdata = R0;
        tick();
        rvalid = 0;
        chk("stray_no_ack", {ack, err}, 2'b00);
        chk("stray_idle", 128'(dbg_state), 128'(ST_IDLE));
        @(negedge clk);
        chk("stray_stall", stall, 1'b0);
        cyc = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
